mips_multicycle_controller: RTL

//  Main control FSM for the multicycle MIPS datapath. Sequences each instruction through

---
 rtl/mips_ctrl_pkg.sv | 66 ++++++
 rtl/mips_multicycle_controller.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mips_ctrl_pkg.sv
// ============================================================================
// Module   : mips_ctrl_pkg
// Brief    : Shared opcode, ALU-op, mux-select and state encodings for the
//            multicycle MIPS control path (controller and alu_decoder).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_ctrl_pkg;

    // Primary opcodes, instr[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // Coarse ALU operation handed to alu_decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU B-operand select
    localparam logic [1:0] ALUSRCB_REG    = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR   = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM    = 2'b10;
    localparam logic [1:0] ALUSRCB_IMMSH2 = 2'b11;

    // Next-PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Controller state encodings; 14 and 15 are unused
    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_MEMADR   = 4'd3,
        ST_MEMREAD  = 4'd4,
        ST_MEMWB    = 4'd5,
        ST_MEMWRITE = 4'd6,
        ST_EXECUTE  = 4'd7,
        ST_ALUWB    = 4'd8,
        ST_BRANCH   = 4'd9,
        ST_ADDIEX   = 4'd10,
        ST_ADDIWB   = 4'd11,
        ST_JUMP     = 4'd12,
        ST_TRAP     = 4'd13
    } ctrl_state_e;

    // True when the opcode belongs to the supported instruction set.
    // bne_en widens the set with bne when branch-not-equal support is built.
    function automatic logic op_is_legal(input logic [5:0] op, input logic bne_en);
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: return 1'b1;
            OP_BNE:                                        return bne_en;
            default:                                       return 1'b0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/mips_multicycle_controller.sv
// ============================================================================
// Module   : mips_multicycle_controller
// Brief    : Moore control FSM for the multicycle MIPS datapath. Steps each
//            instruction through fetch/decode/execute states and drives all
//            datapath enables and mux selects. Optional feature macro:
//            CTRL_BNE_EN (adds bne through the BRANCH state).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_multicycle_controller
    import mips_ctrl_pkg::*;
#(
    parameter int ILLEGAL_TRAP = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    output logic [1:0] alu_op,
    output logic       pc_write,
    output logic       branch,
    output logic       branch_ne,
    output logic       ir_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic       i_or_d,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic       illegal_op,
    output logic [3:0] state
);

`ifdef CTRL_BNE_EN
    localparam logic BNE_EN = 1'b1;
`else
    localparam logic BNE_EN = 1'b0;
`endif

    ctrl_state_e state_q;
    ctrl_state_e state_d;

    // Opcode class captured in DECODE so later states never look at opcode:
    // 1 selects the store path after MEMADR and the not-equal test in BRANCH.
    logic        cls_q;
    logic        cls_d;

    logic        op_legal;

    assign op_legal = op_is_legal(opcode, BNE_EN);
    assign state    = state_q;

    // State and opcode-class registers; reset aborts any instruction at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cls_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
        end
    end

    // Next-state selection; unused encodings fall back to IDLE
    always_comb begin
        state_d = ST_IDLE;
        cls_d   = cls_q;
        case (state_q)
            ST_IDLE:     state_d = ST_FETCH;
            ST_FETCH:    state_d = ST_DECODE;
            ST_DECODE: begin
                cls_d = (opcode == OP_SW) || (BNE_EN && (opcode == OP_BNE));
                if (!op_legal) begin
                    state_d = (ILLEGAL_TRAP != 0) ? ST_TRAP : ST_FETCH;
                end else begin
                    case (opcode)
                        OP_RTYPE:     state_d = ST_EXECUTE;
                        OP_LW, OP_SW: state_d = ST_MEMADR;
                        OP_BEQ:       state_d = ST_BRANCH;
`ifdef CTRL_BNE_EN
                        OP_BNE:       state_d = ST_BRANCH;
`endif
                        OP_ADDI:      state_d = ST_ADDIEX;
                        OP_J:         state_d = ST_JUMP;
                        default:      state_d = ST_FETCH;
                    endcase
                end
            end
            ST_MEMADR:   state_d = cls_q ? ST_MEMWRITE : ST_MEMREAD;
            ST_MEMREAD:  state_d = ST_MEMWB;
            ST_MEMWB:    state_d = ST_FETCH;
            ST_MEMWRITE: state_d = ST_FETCH;
            ST_EXECUTE:  state_d = ST_ALUWB;
            ST_ALUWB:    state_d = ST_FETCH;
            ST_BRANCH:   state_d = ST_FETCH;
            ST_ADDIEX:   state_d = ST_ADDIWB;
            ST_ADDIWB:   state_d = ST_FETCH;
            ST_JUMP:     state_d = ST_FETCH;
            ST_TRAP:     state_d = ST_TRAP;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Moore output decode; everything not set for a state stays 0
    always_comb begin
        alu_op     = ALUOP_ADD;
        pc_write   = 1'b0;
        branch     = 1'b0;
        branch_ne  = 1'b0;
        ir_write   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        i_or_d     = 1'b0;
        mem_to_reg = 1'b0;
        reg_dst    = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = ALUSRCB_REG;
        pc_src     = PCSRC_ALU;
        illegal_op = 1'b0;
        case (state_q)
            ST_FETCH: begin
                ir_write  = 1'b1;
                pc_write  = 1'b1;
                alu_src_b = ALUSRCB_FOUR;
                alu_op    = ALUOP_ADD;
            end
            ST_DECODE: begin
                // Branch target precomputed here as PC+4 + (imm << 2)
                alu_src_b  = ALUSRCB_IMMSH2;
                alu_op     = ALUOP_ADD;
                illegal_op = !op_legal;
            end
            ST_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUSRCB_IMM;
            end
            ST_MEMREAD: begin
                i_or_d = 1'b1;
            end
            ST_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            ST_MEMWRITE: begin
                i_or_d    = 1'b1;
                mem_write = 1'b1;
            end
            ST_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNCT;
            end
            ST_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            ST_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_SUB;
                pc_src    = PCSRC_ALUOUT;
`ifdef CTRL_BNE_EN
                branch    = !cls_q;
                branch_ne = cls_q;
`else
                branch    = 1'b1;
`endif
            end
            ST_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUSRCB_IMM;
            end
            ST_ADDIWB: begin
                reg_write = 1'b1;
            end
            ST_JUMP: begin
                pc_src   = PCSRC_JUMP;
                pc_write = 1'b1;
            end
            default: begin
                // IDLE, TRAP and unused encodings drive nothing
            end
        endcase
    end

endmodule

`default_nettype wire
